// File: rtl/core_pkg.sv
// Shared core types: writeback source select, load funct3 codes and the MEM/WB pipeline record.
package core_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2
  } res_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic              rd_we;
    res_sel_e          res_sel;
    logic [2:0]        funct3;
    logic [XLEN_C-1:0] alu_res;
    logic [XLEN_C-1:0] pc4;
    logic [XLEN_C-1:0] ld_word;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: picks the addressed byte/half of a word and extends it.
import core_pkg::*;

module load_align (
  input  logic [31:0] ld_word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_val
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension; off[0] is ignored for halfwords since misalignment traps upstream
  always_comb begin
    byte_s = ld_word[{off, 3'b000} +: 8];
    half_s = ld_word[{off[1], 4'b0000} +: 16];
    ld_val = ld_word;
    case (funct3)
      F3_LB:   ld_val = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  ld_val = {24'd0, byte_s};
      F3_LH:   ld_val = {{16{half_s[15]}}, half_s};
      F3_LHU:  ld_val = {16'd0, half_s};
      F3_LW:   ld_val = ld_word;
      default: ld_val = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: drives the register file write port and forwarding.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
import core_pkg::*;

module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic            mem_rd_we,
  input  logic [1:0]      mem_res_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_res,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_ld_word,
  input  logic            wb_stall,
  input  logic            wb_flush,
  output logic            wb_valid,
  output logic [4:0]      wb_ad3,
  output logic [XLEN-1:0] wb_wd3,
  output logic            wb_we3,
  output logic [4:0]      wb_fwd_rd,
  output logic [XLEN-1:0] wb_fwd_val,
  output logic            wb_fwd_en
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  mem_wb_t         mem_s;
  mem_wb_t         stage_r;
  logic [XLEN-1:0] ld_val_s;
  logic [XLEN-1:0] wd3_s;
  logic            we3_s;

  // Gather the memory-stage inputs into one pipeline record
  always_comb begin
    mem_s         = '0;
    mem_s.valid   = mem_valid;
    mem_s.rd      = mem_rd;
    mem_s.rd_we   = mem_rd_we;
    mem_s.res_sel = res_sel_e'(mem_res_sel);
    mem_s.funct3  = mem_funct3;
    mem_s.alu_res = mem_alu_res;
    mem_s.pc4     = mem_pc4;
    mem_s.ld_word = mem_ld_word;
  end

  // Pipeline register: reset, then flush (bubble), then stall (hold), then load
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else if (wb_flush) begin
      stage_r <= '0;
    end else if (wb_stall) begin
      stage_r <= stage_r;
    end else begin
      stage_r <= mem_s;
    end
  end

  load_align u_load_align (
    .ld_word (stage_r.ld_word),
    .off     (stage_r.alu_res[1:0]),
    .funct3  (stage_r.funct3),
    .ld_val  (ld_val_s)
  );

  // Writeback source mux; the reserved encoding falls back to the ALU result
  always_comb begin
    wd3_s = stage_r.alu_res;
    case (stage_r.res_sel)
      RES_ALU:  wd3_s = stage_r.alu_res;
      RES_LOAD: wd3_s = ld_val_s;
      RES_PC4:  wd3_s = stage_r.pc4;
      default:  wd3_s = stage_r.alu_res;
    endcase
  end

  // x0 writes are dropped here so the register file needs no special case
  assign we3_s = stage_r.valid & stage_r.rd_we & (stage_r.rd != 5'd0);

  assign wb_valid   = stage_r.valid;
  assign wb_ad3     = stage_r.rd;
  assign wb_wd3     = wd3_s;
  assign wb_we3     = we3_s;
  assign wb_fwd_rd  = stage_r.rd;
  assign wb_fwd_val = wd3_s;
  assign wb_fwd_en  = we3_s;

`ifdef WB_RETIRE_CNT_EN
  // Count each instruction once, on the edge where it leaves WB
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= 64'd0;
    end else if (stage_r.valid && !wb_stall) begin
      retire_cnt <= retire_cnt + 64'd1;
    end else begin
      retire_cnt <= retire_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage; retire counter steps run when WB_RETIRE_CNT_EN is defined.
import core_pkg::*;

module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic        we3;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic [1:0]  mem_res_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_pc4;
  logic [31:0] mem_ld_word;
  logic        wb_stall;
  logic        wb_flush;
  logic        wb_valid;
  logic [4:0]  wb_ad3;
  logic [31:0] wb_wd3;
  logic        wb_we3;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_val;
  logic        wb_fwd_en;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t  sb_q[$];
  string tag_q[$];

  mem_wb_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_rd_we   (mem_rd_we),
    .mem_res_sel (mem_res_sel),
    .mem_funct3  (mem_funct3),
    .mem_alu_res (mem_alu_res),
    .mem_pc4     (mem_pc4),
    .mem_ld_word (mem_ld_word),
    .wb_stall    (wb_stall),
    .wb_flush    (wb_flush),
    .wb_valid    (wb_valid),
    .wb_ad3      (wb_ad3),
    .wb_wd3      (wb_wd3),
    .wb_we3      (wb_we3),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_val  (wb_fwd_val),
    .wb_fwd_en   (wb_fwd_en)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic stall, input logic flush);
    mem_valid   = v;
    mem_rd      = rd;
    mem_rd_we   = we;
    mem_res_sel = sel;
    mem_funct3  = f3;
    mem_alu_res = alu;
    mem_pc4     = pc4;
    mem_ld_word = ld;
    wb_stall    = stall;
    wb_flush    = flush;
  endtask

  task automatic expect_next(input string tag, input logic v, input logic [4:0] ad3,
                             input logic [31:0] wd3, input logic we3);
    exp_t e;
    e.valid = v;
    e.ad3   = ad3;
    e.wd3   = wd3;
    e.we3   = we3;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge, then pop the oldest expectation and compare every WB output
  task automatic tick_check();
    exp_t  e;
    string t;
    tick();
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed %0d entries expected >0", sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (wb_valid === e.valid) else begin
        errors++; $error("FAIL %s.valid observed %b expected %b", t, wb_valid, e.valid);
      end
      checks++;
      assert (wb_ad3 === e.ad3) else begin
        errors++; $error("FAIL %s.ad3 observed %0d expected %0d", t, wb_ad3, e.ad3);
      end
      checks++;
      assert (wb_wd3 === e.wd3) else begin
        errors++; $error("FAIL %s.wd3 observed %h expected %h", t, wb_wd3, e.wd3);
      end
      checks++;
      assert (wb_we3 === e.we3) else begin
        errors++; $error("FAIL %s.we3 observed %b expected %b", t, wb_we3, e.we3);
      end
      checks++;
      assert ({wb_fwd_rd, wb_fwd_val, wb_fwd_en} === {e.ad3, e.wd3, e.we3}) else begin
        errors++;
        $error("FAIL %s.fwd observed %0d/%h/%b expected %0d/%h/%b", t,
               wb_fwd_rd, wb_fwd_val, wb_fwd_en, e.ad3, e.wd3, e.we3);
      end
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic check_cnt(input string tag, input logic [63:0] exp_cnt);
    checks++;
    assert (retire_cnt === exp_cnt) else begin
      errors++; $error("FAIL %s observed %0d expected %0d", tag, retire_cnt, exp_cnt);
    end
  endtask
`endif

  localparam logic [31:0] LDW = 32'h80FF_7F01;

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'h1111_1111, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset held for two edges while the memory stage claims a valid instruction
    expect_next("rst0", 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
`ifdef WB_RETIRE_CNT_EN
    check_cnt("rst0.cnt", 64'd0);
`endif
    expect_next("rst1", 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
`ifdef WB_RETIRE_CNT_EN
    check_cnt("rst1.cnt", 64'd0);
`endif
    rst = 1'b0;

    // ALU writeback, then the same to x0
    drive(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_next("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b1);
    tick_check();
    drive(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_next("alu_x0", 1'b1, 5'd0, 32'h1234_5678, 1'b0);
    tick_check();

    // Loads from 0x80FF_7F01 at various offsets
    drive(1'b1, 5'd7, 1'b1, 2'd1, F3_LB, 32'h0000_1003, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lb_off3", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1);
    tick_check();
    drive(1'b1, 5'd7, 1'b1, 2'd1, F3_LBU, 32'h0000_1003, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lbu_off3", 1'b1, 5'd7, 32'h0000_0080, 1'b1);
    tick_check();
    drive(1'b1, 5'd7, 1'b1, 2'd1, F3_LB, 32'h0000_1001, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lb_off1", 1'b1, 5'd7, 32'h0000_007F, 1'b1);
    tick_check();
    drive(1'b1, 5'd8, 1'b1, 2'd1, F3_LH, 32'h0000_1002, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lh_off2", 1'b1, 5'd8, 32'hFFFF_80FF, 1'b1);
    tick_check();
    drive(1'b1, 5'd8, 1'b1, 2'd1, F3_LH, 32'h0000_1003, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lh_off3", 1'b1, 5'd8, 32'hFFFF_80FF, 1'b1);
    tick_check();
    drive(1'b1, 5'd8, 1'b1, 2'd1, F3_LHU, 32'h0000_1000, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lhu_off0", 1'b1, 5'd8, 32'h0000_7F01, 1'b1);
    tick_check();
    drive(1'b1, 5'd9, 1'b1, 2'd1, F3_LW, 32'h0000_1002, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("lw", 1'b1, 5'd9, 32'h80FF_7F01, 1'b1);
    tick_check();
    drive(1'b1, 5'd9, 1'b1, 2'd1, 3'b011, 32'h0000_1001, 32'd0, LDW, 1'b0, 1'b0);
    expect_next("ld_undef", 1'b1, 5'd9, 32'h80FF_7F01, 1'b1);
    tick_check();

    // PC+4 source, reserved select, no-write and invalid instructions
    drive(1'b1, 5'd1, 1'b1, 2'd2, 3'd0, 32'hDEAD_0000, 32'h0000_0104, LDW, 1'b0, 1'b0);
    expect_next("pc4", 1'b1, 5'd1, 32'h0000_0104, 1'b1);
    tick_check();
    drive(1'b1, 5'd2, 1'b1, 2'd3, 3'd0, 32'h0000_CAFE, 32'h0000_0204, LDW, 1'b0, 1'b0);
    expect_next("sel_rsvd", 1'b1, 5'd2, 32'h0000_CAFE, 1'b1);
    tick_check();
    drive(1'b1, 5'd3, 1'b0, 2'd0, 3'd0, 32'h0000_0033, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_next("no_we", 1'b1, 5'd3, 32'h0000_0033, 1'b0);
    tick_check();
    drive(1'b0, 5'd3, 1'b1, 2'd0, 3'd0, 32'h0000_0044, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_next("invalid", 1'b0, 5'd3, 32'h0000_0044, 1'b0);
    tick_check();

    // Stall holds A while B waits; stall+flush inserts a bubble; release lets B in
    drive(1'b1, 5'd10, 1'b1, 2'd0, 3'd0, 32'hAAAA_0001, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_next("A", 1'b1, 5'd10, 32'hAAAA_0001, 1'b1);
    tick_check();
    drive(1'b1, 5'd11, 1'b1, 2'd0, 3'd0, 32'hBBBB_0002, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_next("A_held", 1'b1, 5'd10, 32'hAAAA_0001, 1'b1);
      tick_check();
    end
    wb_flush = 1'b1;
    expect_next("stall_flush", 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    expect_next("B", 1'b1, 5'd11, 32'hBBBB_0002, 1'b1);
    tick_check();

    // Reset during a stall discards the held instruction
    drive(1'b1, 5'd12, 1'b1, 2'd0, 3'd0, 32'hCCCC_0003, 32'd0, 32'd0, 1'b1, 1'b0);
    rst = 1'b1;
    expect_next("rst_stall", 1'b0, 5'd0, 32'd0, 1'b0);
    tick_check();
`ifdef WB_RETIRE_CNT_EN
    check_cnt("rst_stall.cnt", 64'd0);
`endif
    rst = 1'b0;
    wb_stall = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    // Ten instructions, two stall cycles, the tenth flushed: nine retire
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cnt("cnt_start", 64'd0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 5'd2, 1'b1, 2'd0, 3'd0, 32'(i), 32'd0, 32'd0, 1'b0, 1'b0);
      if (i == 3) begin
        wb_stall = 1'b1;
        tick();
        tick();
        wb_stall = 1'b0;
      end
      if (i == 10) wb_flush = 1'b1;
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_cnt("cnt_nine", 64'd9);

    // Wrap from all-ones to zero
    drive(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'h0000_0055, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    check_cnt("cnt_preload", 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_cnt("cnt_wrap", 64'd0);
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++; $error("FAIL sb_leftover observed %0d entries expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the in-order RISC-V core. It captures one instruction per cycle from the memory stage and aligns and sign/zero-extends load data. It selects the writeback value and drives the register file write port (address, data, enable) in the same cycle. It also exports the writeback value for forwarding into the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports (clock and reset first):
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_valid  input  1  memory stage holds a valid instruction.
- mem_rd  input  5  destination register index.
- mem_rd_we  input  1  instruction writes rd.
- mem_res_sel  input  2  writeback source: 0 = ALU, 1 = LOAD, 2 = PC+4; 3 is reserved and treated as ALU.
- mem_funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_alu_res  input  32  ALU result; this is also the load address.
- mem_pc4  input  32  PC+4 of the instruction.
- mem_ld_word  input  32  raw aligned 32-bit word returned by data memory.
- wb_stall  input  1  hold the current WB contents.
- wb_flush  input  1  replace the WB contents with a bubble.
- wb_valid  output  1  WB holds a valid instruction.
- wb_ad3  output  5  register file write address.
- wb_wd3  output  32  register file write data.
- wb_we3  output  1  register file write enable.
- wb_fwd_rd  output  5  forwarding destination index; equals wb_ad3.
- wb_fwd_val  output  32  forwarding value; equals wb_wd3.
- wb_fwd_en  output  1  forwarding is valid; equals wb_we3.
- retire_cnt  output  64  retired-instruction count; present only with WB_RETIRE_CNT_EN.

## Operation
- Pipeline register fields: valid, rd, rd_we, res_sel, funct3, alu_res, pc4, ld_word.
- Update priority on each rising edge: rst > wb_flush > wb_stall > load.
  - rst: valid = 0; all other fields = 0.
  - wb_flush: valid = 0; the other fields are don't-care, but they are driven to 0.
  - wb_stall: all fields hold.
  - Otherwise: all fields load from the mem_* inputs, and valid = mem_valid.
- Load alignment is combinational on the registered fields, using off = alu_res[1:0].
  - LB/LBU: byte = ld_word[8*off +: 8]. LB sign-extends bit 7; LBU zero-extends.
  - LH/LHU: half = ld_word[16*off[1] +: 16]. off[0] is ignored, because misalignment is trapped upstream. LH sign-extends bit 15; LHU zero-extends.
  - LW: the whole word; off is ignored.
  - Undefined funct3 values: wd3 = ld_word unmodified.
- Writeback mux: wd3 = ALU → alu_res; LOAD → aligned load value; PC+4 → pc4.
- wb_we3 = valid & rd_we & (rd != 0). Writes to x0 are suppressed here, not in the register file.
- wb_ad3 = rd and wb_wd3 = mux output, driven even when wb_we3 = 0.
- While stalled, wb_we3 stays asserted for the held instruction. The repeated write is idempotent.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on wb_* outputs after edge N, and the register file writes at edge N+1.
- wb_* outputs are combinational from the register; there is no input-to-output combinational path.
- Reset values: wb_valid = 0, wb_we3 = 0, wb_ad3 = 0, wb_wd3 = 0, all fwd outputs = 0, retire_cnt = 0.
- Simultaneous wb_stall and wb_flush: flush wins and a bubble is inserted.
- Reset asserted mid-stall clears the stage; the held instruction is lost and is not counted.
- Forwarding outputs are valid in the same cycle as the write. The register file has no write-through, so the execute stage must consume wb_fwd_*.

## Configuration
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - 64-bit retire_cnt increments by 1 on every rising edge where valid = 1, wb_stall = 0 and rst = 0. This counts each instruction exactly once, as it leaves WB.
  - Flushed instructions are never counted.
  - The counter wraps from 2^64−1 to 0.
- Undefined: the port and the counter are absent, and the stage behaves identically otherwise.

## Structure
- Shared package core_pkg holds:
  - the res_sel_e enum (RES_ALU, RES_LOAD, RES_PC4);
  - the funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - the packed struct mem_wb_t holding the pipeline fields.
- One sub-module, load_align: purely combinational (ld_word, off, funct3) → 32-bit value. It is reused by any future load-store unit.

## Test plan
- Reset: hold rst for 2 cycles with mem_valid = 1 → wb_valid = 0, wb_we3 = 0, wb_wd3 = 0 and retire_cnt = 0 throughout.
- ALU writeback: mem_rd = 5, res_sel = ALU, alu_res = 0x1234_5678 → next cycle wb_ad3 = 5, wb_wd3 = 0x1234_5678, wb_we3 = 1. Repeating with mem_rd = 0 → wb_we3 = 0.
- Loads: ld_word = 0x80FF_7F01.
  - LB at off 3 → 0xFFFF_FF80; LBU at off 3 → 0x0000_0080.
  - LH at off 2 → 0xFFFF_80FF; LHU at off 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- PC+4: res_sel = PC4, pc4 = 0x0000_0104, rd = 1 → wb_wd3 = 0x0000_0104.
- Stall/flush: load instruction A, then stall 3 cycles while presenting B → A is held and wb_we3 stays 1. Then assert stall and flush together → wb_valid = 0 next cycle. Release both → B appears.
- Retire counter (WB_RETIRE_CNT_EN): 10 valid instructions with 2 stall cycles and 1 flush of the 10th → retire_cnt = 9. Preload the counter to 2^64−1 via force and retire 1 instruction → 0.
